// File: rtl/instr_fetch_if.sv
// Load-port and fetch-handshake bundle between instr_fetch and its neighbours.
// The master side loads the store and consumes instructions; the slave side is the fetch stage.
interface instr_fetch_if #(
  parameter int unsigned ADR_W   = 8,
  parameter int unsigned INSTR_W = 10
);
  logic               memWrite;
  logic [ADR_W-1:0]   adr;
  logic [INSTR_W-1:0] instruct;
  logic               start;
  logic               branch_valid;
  logic [ADR_W-1:0]   branch_target;
  logic               instr_ready;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [ADR_W-1:0]   pc_out;
  logic               halted;
  logic               busy;

  modport master (
    output memWrite, adr, instruct, start, branch_valid, branch_target, instr_ready,
    input  instr_valid, instr_out, pc_out, halted, busy
  );

  modport slave (
    input  memWrite, adr, instruct, start, branch_valid, branch_target, instr_ready,
    output instr_valid, instr_out, pc_out, halted, busy
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: loadable instruction store, PC sequencing, valid/ready
// delivery with branch redirect and halt detection.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; store writable, waits for start
// READ    | pc presented to the store; word captured on the next edge
// VALID   | instr_out/pc_out offered downstream until accepted/redirected
// HALTED  | halt word fetched; store writable, waits for start
module instr_fetch #(
  parameter int unsigned        ADR_W      = 8,
  parameter int unsigned        INSTR_W    = 10,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 10'h3FF,
  parameter logic [ADR_W-1:0]   START_PC   = 8'h00
) (
  input logic          clk,
  input logic          reset,
  instr_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [ADR_W-1:0]   pc_out_q, pc_out_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic               busy_q, busy_d;

  logic [INSTR_W-1:0] mem [0:(1<<ADR_W)-1];
  logic [INSTR_W-1:0] rdata;
  logic               mem_we;

  // The store is only writable while no fetch is in flight.
  assign mem_we = bus.memWrite && ((state_q == S_IDLE) || (state_q == S_HALTED));

  // Read port: address is pc during READ, the word lands in instr_out on the next edge.
  assign rdata = mem[pc_q];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.adr] <= bus.instruct;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= START_PC;
      instr_out_q   <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = START_PC;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.branch_valid) begin
          pc_d = bus.branch_target;
        end else if (rdata == HALT_INSTR) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.branch_valid) begin
          pc_d    = bus.branch_target;
          state_d = S_READ;
        end else if (bus.instr_ready) begin
          pc_d    = pc_q + ADR_W'(1);
          state_d = S_READ;
        end
      end
      S_HALTED: begin
        if (bus.start) begin
          pc_d    = START_PC;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A redirect during READ drops the in-flight word, so the capture is suppressed.
  always_comb begin
    instr_out_d = instr_out_q;
    pc_out_d    = pc_out_q;
    if ((state_q == S_READ) && !bus.branch_valid) begin
      instr_out_d = rdata;
      pc_out_d    = pc_q;
    end
    instr_valid_d = (state_d == S_VALID);
    halted_d      = (state_d == S_HALTED);
    busy_d        = (state_d == S_READ) || (state_d == S_VALID);
  end

  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.halted      = halted_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected {instr, pc} pairs are queued when a
// program is launched and popped whenever the downstream side accepts a word.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  int   cmp  = 0;
  int   mism = 0;
  logic [17:0] sb [$];
  logic [17:0] exp_e;
  logic [5:0]  ev_valid;
  logic [5:0]  ev_halted;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADR_W(8), .INSTR_W(10)) bus ();

  instr_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Looks at the handshake 1 ns before the rising edge, with inputs final.
  task automatic mon();
    if (reset === 1'b1 && bus.instr_valid === 1'b1) begin
      chk("halt_leak", {31'd0, bus.instr_out === 10'h3FF}, 0);
      if (bus.instr_ready === 1'b1) begin
        cmp++;
        assert (sb.size() != 0) else begin
          mism++;
          $error("FAIL sb_empty: observed accept of 'h%0h at pc 'h%0h, expected no accept",
                 bus.instr_out, bus.pc_out);
        end
        if (sb.size() != 0) begin
          exp_e = sb.pop_front();
          chk("acc_instr", {22'd0, bus.instr_out}, {22'd0, exp_e[17:8]});
          chk("acc_pc", {24'd0, bus.pc_out}, {24'd0, exp_e[7:0]});
        end
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge n cycles later.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      #4;
      mon();
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [9:0] d);
    bus.memWrite = 1'b1;
    bus.adr      = a;
    bus.instruct = d;
    cyc(1);
    bus.memWrite = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_valid", {31'd0, bus.instr_valid}, 1);
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (bus.halted !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_halted", {31'd0, bus.halted}, 1);
  endtask

  task automatic launch();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    reset             = 1'b0;
    bus.memWrite      = 1'b0;
    bus.adr           = '0;
    bus.instruct      = '0;
    bus.start         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready   = 1'b0;
    @(negedge clk);
    cyc(2);

    chk("rst_valid", {31'd0, bus.instr_valid}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_halted", {31'd0, bus.halted}, 0);
    chk("rst_instr", {22'd0, bus.instr_out}, 0);
    chk("rst_pc", {24'd0, bus.pc_out}, 0);
    reset = 1'b1;
    cyc(1);
    chk("idle_busy", {31'd0, bus.busy}, 0);

    // Basic program, downstream always ready.
    wr(8'h00, 10'h011);
    wr(8'h01, 10'h022);
    wr(8'h02, 10'h3FF);
    sb.push_back({10'h011, 8'h00});
    sb.push_back({10'h022, 8'h01});
    bus.instr_ready = 1'b1;
    launch();
    ev_valid  = 6'b001010;
    ev_halted = 6'b100000;
    chk("run_busy", {31'd0, bus.busy}, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("run_valid_%0d", i), {31'd0, bus.instr_valid}, {31'd0, ev_valid[i]});
      chk($sformatf("run_halted_%0d", i), {31'd0, bus.halted}, {31'd0, ev_halted[i]});
      if (i < 5) cyc(1);
    end
    chk("halt_busy", {31'd0, bus.busy}, 0);

    // Backpressure: first word held for five cycles.
    bus.instr_ready = 1'b0;
    sb.push_back({10'h011, 8'h00});
    launch();
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, bus.instr_valid}, 1);
      chk("bp_instr", {22'd0, bus.instr_out}, 32'h011);
      chk("bp_pc", {24'd0, bus.pc_out}, 0);
      cyc(1);
    end
    sb.push_back({10'h022, 8'h01});
    bus.instr_ready = 1'b1;
    wait_halted(20);

    // Branch while VALID, downstream not ready.
    wr(8'h05, 10'h155);
    wr(8'h06, 10'h3FF);
    bus.instr_ready = 1'b0;
    launch();
    wait_valid(10);
    chk("br_pre_instr", {22'd0, bus.instr_out}, 32'h011);
    sb.push_back({10'h155, 8'h05});
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h05;
    cyc(1);
    bus.branch_valid = 1'b0;
    cyc(1);
    chk("br_instr", {22'd0, bus.instr_out}, 32'h155);
    chk("br_pc", {24'd0, bus.pc_out}, 32'h05);
    bus.instr_ready = 1'b1;
    wait_halted(10);

    // Branch while READ: the word at pc 0 must never be offered.
    sb.push_back({10'h155, 8'h05});
    launch();
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h05;
    cyc(1);
    bus.branch_valid = 1'b0;
    chk("brr_valid", {31'd0, bus.instr_valid}, 0);
    wait_halted(10);

    // Wrap, with a branch that also counts as an accept.
    wr(8'hFF, 10'h0AA);
    wr(8'h00, 10'h0BB);
    bus.instr_ready = 1'b0;
    launch();
    wait_valid(10);
    chk("wrap_pre_instr", {22'd0, bus.instr_out}, 32'h0BB);
    sb.push_back({10'h0BB, 8'h00});
    sb.push_back({10'h0AA, 8'hFF});
    sb.push_back({10'h0BB, 8'h00});
    sb.push_back({10'h022, 8'h01});
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'hFF;
    cyc(1);
    bus.branch_valid = 1'b0;
    wait_halted(20);

    // Write gating: ignored while busy, honoured while halted.
    wr(8'h00, 10'h011);
    bus.instr_ready = 1'b0;
    sb.push_back({10'h011, 8'h00});
    sb.push_back({10'h022, 8'h01});
    launch();
    wait_valid(10);
    chk("gate_busy", {31'd0, bus.busy}, 1);
    wr(8'h01, 10'h3C3);
    bus.instr_ready = 1'b1;
    wait_halted(20);
    wr(8'h01, 10'h3C3);
    sb.push_back({10'h011, 8'h00});
    sb.push_back({10'h3C3, 8'h01});
    launch();
    wait_halted(20);

    // Reset while VALID, then write+start together from IDLE.
    bus.instr_ready = 1'b0;
    launch();
    wait_valid(10);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("mid_rst_valid", {31'd0, bus.instr_valid}, 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_halted", {31'd0, bus.halted}, 0);
    chk("mid_rst_pc", {24'd0, bus.pc_out}, 0);
    cyc(1);
    chk("mid_rst_idle", {31'd0, bus.busy}, 0);
    sb.push_back({10'h077, 8'h00});
    sb.push_back({10'h3C3, 8'h01});
    bus.memWrite    = 1'b1;
    bus.adr         = 8'h00;
    bus.instruct    = 10'h077;
    bus.instr_ready = 1'b1;
    bus.start       = 1'b1;
    cyc(1);
    bus.memWrite = 1'b0;
    bus.start    = 1'b0;
    wait_halted(20);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion by 200000 ns, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
